// File: rtl/wb_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_stage_pkg
// Shared pipeline constants and the MEM/WB bundle type used by mem_stage
// (producer) and wb_stage (consumer).
//   DATA_W     : register / bus width
//   REG_ADDR_W : register index width
//   NUM_REGS   : register count (2**REG_ADDR_W)
//   REG_ZERO   : hard-wired zero register index
//   mem_wb_t   : {regwrite, rd, rpzero, value} as carried MEM -> WB
//   wb_commits : true when a MEM/WB bundle architecturally writes a register
// -----------------------------------------------------------------------------
package wb_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int RETIRE_W   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                  regwrite;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rpzero;
    logic [DATA_W-1:0]     value;
  } mem_wb_t;

  // A killed instruction or a write aimed at R0 never reaches the file.
  function automatic logic wb_commits(input mem_wb_t b);
    return b.regwrite & ~b.rpzero & (b.rd != REG_ZERO);
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// -----------------------------------------------------------------------------
// wb_stage_if
// MEM -> WB bundle. mem_stage drives it through the master modport, wb_stage
// consumes it through the slave modport.
//   RegWrite_MEM : MEM-stage instruction writes a register
//   Rd3_MEM      : MEM-stage destination index
//   WBdata_out   : selected write-back value (ALU, load or NPC)
//   RPzero_MEM   : MEM-stage instruction is killed (predicate false)
// -----------------------------------------------------------------------------
interface wb_stage_if #(
  parameter int DATA_W     = wb_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W
);

  logic                  RegWrite_MEM;
  logic [REG_ADDR_W-1:0] Rd3_MEM;
  logic [DATA_W-1:0]     WBdata_out;
  logic                  RPzero_MEM;

  modport master (
    output RegWrite_MEM,
    output Rd3_MEM,
    output WBdata_out,
    output RPzero_MEM
  );

  modport slave (
    input RegWrite_MEM,
    input Rd3_MEM,
    input WBdata_out,
    input RPzero_MEM
  );

endinterface

// File: rtl/wb_stage_reg_file.sv
// -----------------------------------------------------------------------------
// wb_stage_reg_file
// General-purpose register file: one write port, two combinational read ports
// with write-first bypass, R0 reads as zero.
//   clk, reset            : clock, async active-high reset (clears every entry)
//   i_we/i_waddr/i_wdata  : write port; i_we is already qualified (never R0)
//   i_raddr_a/i_raddr_b   : read addresses
//   o_rdata_a/o_rdata_b   : read data
// -----------------------------------------------------------------------------
module wb_stage_reg_file
  import wb_stage_pkg::*;
#(
  parameter int DATA_W     = wb_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_we,
  input  logic [REG_ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]     i_wdata,
  input  logic [REG_ADDR_W-1:0] i_raddr_a,
  input  logic [REG_ADDR_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]     o_rdata_a,
  output logic [DATA_W-1:0]     o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NUM_REGS];

  // NOTE: this array is built from flops, not a RAM macro, and the pipeline
  // must observe all-zero registers straight out of reset, so every entry is
  // cleared. A RAM-backed file could not be reset this way.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (i_we) begin
      // NOTE: state updates use non-blocking assignment so every flop samples
      // pre-edge values regardless of process ordering.
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // R0 first, then the value currently in WB (not yet in the array), then
  // the stored entry.
  function automatic logic [DATA_W-1:0] read_port(input logic [REG_ADDR_W-1:0] addr);
    if (addr == REG_ZERO)             return '0;
    if (i_we && (addr == i_waddr))    return i_wdata;
    return r_regs[addr];
  endfunction

  // NOTE: every output of a combinational block gets a value on every path;
  // assigning defaults first keeps latches from being inferred.
  always_comb begin
    o_rdata_a = '0;
    o_rdata_b = '0;
    o_rdata_a = read_port(i_raddr_a);
    o_rdata_b = read_port(i_raddr_b);
  end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back stage: MEM/WB pipeline register, commit qualification, register
// file with bypassed decode read ports, and WB-side forwarding outputs.
// Optional feature macro: WB_RETIRE_CNT_EN adds the 32-bit retire_cnt port.
//   clk, reset        : clock, async active-high reset
//   mem (slave)       : MEM -> WB bundle (wb_stage_if)
//   Rs_ID, Rt_ID      : decode read addresses
//   BusA, BusB        : decode read data
//   RegWrite_WB, Rd_WB, RPzero_WB, WBvalue_WB : latched MEM/WB fields
//   retire_cnt        : committed-write counter (WB_RETIRE_CNT_EN only)
// -----------------------------------------------------------------------------
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int DATA_W     = wb_stage_pkg::DATA_W,
  parameter int REG_ADDR_W = wb_stage_pkg::REG_ADDR_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  wb_stage_if.slave             mem,
  input  logic [REG_ADDR_W-1:0] Rs_ID,
  input  logic [REG_ADDR_W-1:0] Rt_ID,
  output logic [DATA_W-1:0]     BusA,
  output logic [DATA_W-1:0]     BusB,
  output logic                  RegWrite_WB,
  output logic [REG_ADDR_W-1:0] Rd_WB,
  output logic                  RPzero_WB,
  output logic [DATA_W-1:0]     WBvalue_WB
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0]   retire_cnt
`endif
);

  logic                  r_regwrite;
  logic [REG_ADDR_W-1:0] r_rd;
  logic                  r_rpzero;
  logic [DATA_W-1:0]     r_value;
  logic                  w_commit;

  // MEM/WB register: free-running, WB never stalls the pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_regwrite <= 1'b0;
      r_rd       <= '0;
      r_rpzero   <= 1'b0;
      r_value    <= '0;
    end else begin
      r_regwrite <= mem.RegWrite_MEM;
      r_rd       <= mem.Rd3_MEM;
      r_rpzero   <= mem.RPzero_MEM;
      r_value    <= mem.WBdata_out;
    end
  end

  // Killed instructions still show their fields on the outputs; the hazard
  // unit looks at RPzero_WB and suppresses its own forwarding.
  assign w_commit = r_regwrite & ~r_rpzero & (r_rd != REG_ZERO);

  assign RegWrite_WB = r_regwrite;
  assign Rd_WB       = r_rd;
  assign RPzero_WB   = r_rpzero;
  assign WBvalue_WB  = r_value;

  wb_stage_reg_file #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W),
    .NUM_REGS   (NUM_REGS)
  ) u_reg_file (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_commit),
    .i_waddr   (r_rd),
    .i_wdata   (r_value),
    .i_raddr_a (Rs_ID),
    .i_raddr_b (Rt_ID),
    .o_rdata_a (BusA),
    .o_rdata_b (BusB)
  );

`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0] r_retire_cnt;

  // Counts on the edge the write lands in the array; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retire_cnt <= '0;
    else if (w_commit) r_retire_cnt <= r_retire_cnt + 1'b1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Scoreboard bench for wb_stage. The reference model keeps the architectural
// register state as seen by decode: an instruction's result becomes visible
// the moment it enters WB (no notion of array vs bypass), plus the latched
// MEM/WB bundle and a retire count.
// -----------------------------------------------------------------------------
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [REG_ADDR_W-1:0] Rs_ID, Rt_ID;
  logic [DATA_W-1:0]     BusA, BusB, WBvalue_WB;
  logic                  RegWrite_WB, RPzero_WB;
  logic [REG_ADDR_W-1:0] Rd_WB;
`ifdef WB_RETIRE_CNT_EN
  logic [RETIRE_W-1:0]   retire_cnt;
`endif

  wb_stage_if mem_if ();

  wb_stage dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (mem_if),
    .Rs_ID       (Rs_ID),
    .Rt_ID       (Rt_ID),
    .BusA        (BusA),
    .BusB        (BusB),
    .RegWrite_WB (RegWrite_WB),
    .Rd_WB       (Rd_WB),
    .RPzero_WB   (RPzero_WB),
    .WBvalue_WB  (WBvalue_WB)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt  (retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] busa;
    logic [DATA_W-1:0] busb;
    mem_wb_t           wb;
    logic [31:0]       cnt;
  } exp_t;

  exp_t              q[$];
  int                checks = 0;
  int                errors = 0;
  logic [DATA_W-1:0] arch [NUM_REGS];
  mem_wb_t           wb_m;
  logic [31:0]       cnt_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NUM_REGS; i++) arch[i] = '0;
    wb_m  = '0;
    cnt_m = '0;
  endtask

  // One cycle of stimulus: drive at the falling edge, record what the
  // outputs must show until the next rising edge, then advance the model
  // across that rising edge.
  task automatic drive(input bit rst_v, input bit rw, input logic [REG_ADDR_W-1:0] rd,
                       input logic [DATA_W-1:0] data, input bit rp,
                       input logic [REG_ADDR_W-1:0] rs, input logic [REG_ADDR_W-1:0] rt);
    exp_t e;
    @(negedge clk);
    reset               = rst_v;
    mem_if.RegWrite_MEM = rw;
    mem_if.Rd3_MEM      = rd;
    mem_if.WBdata_out   = data;
    mem_if.RPzero_MEM   = rp;
    Rs_ID               = rs;
    Rt_ID               = rt;
    if (rst_v) model_clear();
    e.busa = (rs == REG_ZERO) ? '0 : arch[rs];
    e.busb = (rt == REG_ZERO) ? '0 : arch[rt];
    e.wb   = wb_m;
    e.cnt  = cnt_m;
    q.push_back(e);
    if (!rst_v) begin
      if (wb_commits(wb_m)) cnt_m = cnt_m + 32'd1;
      wb_m = '{regwrite: rw, rd: rd, rpzero: rp, value: data};
      if (wb_commits(wb_m)) arch[rd] = data;
    end
  endtask

  // Monitor: compares every cycle, well after the falling-edge drive and
  // well before the next rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("BusA",        BusA,        e.busa);
        check("BusB",        BusB,        e.busb);
        check("RegWrite_WB", RegWrite_WB, e.wb.regwrite);
        check("Rd_WB",       Rd_WB,       e.wb.rd);
        check("RPzero_WB",   RPzero_WB,   e.wb.rpzero);
        check("WBvalue_WB",  WBvalue_WB,  e.wb.value);
`ifdef WB_RETIRE_CNT_EN
        check("retire_cnt",  retire_cnt,  e.cnt);
`endif
      end
    end
  end

  initial begin : stimulus
    logic [REG_ADDR_W-1:0] rd, rs, rt, last_rd;
    logic [DATA_W-1:0]     data;
    bit                    rw, rp, rst_v;

    reset               = 1'b1;
    mem_if.RegWrite_MEM = 1'b0;
    mem_if.Rd3_MEM      = '0;
    mem_if.WBdata_out   = '0;
    mem_if.RPzero_MEM   = 1'b0;
    Rs_ID               = '0;
    Rt_ID               = '0;
    model_clear();

    // Reset state.
    drive(1, 0, 0, 0, 0, 5'd3, 5'd31);
    drive(0, 0, 0, 0, 0, 5'd3, 5'd31);

    // R3 = 15: bypass the cycle it sits in WB, then from the array.
    drive(0, 1, 5'd3, 32'd15, 0, 5'd3, 5'd0);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd3, 5'd3);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd3, 5'd0);

    // Writes to R0 never land.
    drive(0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 5'd0);
    drive(0, 1, 5'd0, 32'hDEADBEEF, 0, 5'd0, 5'd0);
    drive(0, 0, 5'd0, 32'd0,        0, 5'd0, 5'd0);

    // R4 = 7, then a killed write of 99 to R4.
    drive(0, 1, 5'd4, 32'd7,  0, 5'd0, 5'd4);
    drive(0, 1, 5'd4, 32'd99, 1, 5'd0, 5'd4);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd0, 5'd4);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd0, 5'd4);

    // Back-to-back R31 writes, both buses on R31.
    drive(0, 1, 5'd31, 32'd100, 0, 5'd31, 5'd31);
    drive(0, 1, 5'd31, 32'd200, 0, 5'd31, 5'd31);
    drive(0, 0, 5'd0,  32'd0,   0, 5'd31, 5'd31);
    drive(0, 0, 5'd0,  32'd0,   0, 5'd31, 5'd31);

`ifdef WB_RETIRE_CNT_EN
    // Preload the counter just below wrap while no commit is in flight.
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);
    #4;
    dut.r_retire_cnt = 32'hFFFFFFFE;
    cnt_m            = 32'hFFFFFFFE;
    drive(0, 1, 5'd1, 32'd1, 0, 5'd1, 5'd2);
    drive(0, 1, 5'd2, 32'd2, 0, 5'd1, 5'd2);
    drive(0, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
    drive(0, 0, 5'd0, 32'd0, 0, 5'd1, 5'd2);
`endif

    // Reset while a commit to R5 is pending in WB: write discarded.
    drive(0, 1, 5'd5, 32'd55, 0, 5'd5, 5'd31);
    drive(1, 1, 5'd6, 32'd66, 0, 5'd5, 5'd31);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd5, 5'd31);
    drive(0, 0, 5'd0, 32'd0,  0, 5'd5, 5'd6);

    // Randomized traffic, small register window for frequent hazards.
    last_rd = '0;
    for (int i = 0; i < 400; i++) begin
      rw    = ($urandom_range(0, 3) != 0);
      rp    = ($urandom_range(0, 4) == 0);
      rd    = ($urandom_range(0, 5) == 0) ? REG_ADDR_W'(31) : REG_ADDR_W'($urandom_range(0, 7));
      data  = $urandom();
      rs    = ($urandom_range(0, 1) == 0) ? last_rd : REG_ADDR_W'($urandom_range(0, 7));
      rt    = ($urandom_range(0, 2) == 0) ? rs      : REG_ADDR_W'($urandom_range(0, 31));
      rst_v = ($urandom_range(0, 99) == 0);
      drive(rst_v, rw, rd, data, rp, rs, rt);
      last_rd = rd;
    end
    drive(0, 0, 5'd0, 32'd0, 0, 5'd0, 5'd0);

    // Let the monitor drain, with a bounded wait.
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #3;
    check("scoreboard_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the 5-stage pipeline: the consuming end of the MEM→WB interface. It latches the MEM-stage result into the MEM/WB pipeline register, commits it to the general-purpose register file, and serves the two decode-stage read ports with write-first bypass. It also drives the WB-side destination, write-enable and predicate signals consumed by the hazard unit's WB forwarding path.

## Interface

Parameters:
- DATA_W, 32, register and bus width
- REG_ADDR_W, 5, register index width
- NUM_REGS, 32, register count; must equal 2**REG_ADDR_W

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- RegWrite_MEM  in  1  MEM-stage instruction writes a register
- Rd3_MEM  in  REG_ADDR_W  MEM-stage destination
- WBdata_out  in  DATA_W  MEM-stage selected write-back value (ALU, load or NPC)
- RPzero_MEM  in  1  MEM-stage instruction is killed (predicate false)
- Rs_ID  in  REG_ADDR_W  decode read address A
- Rt_ID  in  REG_ADDR_W  decode read address B
- BusA  out  DATA_W  value of Rs_ID
- BusB  out  DATA_W  value of Rt_ID
- RegWrite_WB  out  1  registered RegWrite_MEM
- Rd_WB  out  REG_ADDR_W  registered Rd3_MEM
- RPzero_WB  out  1  registered RPzero_MEM
- WBvalue_WB  out  DATA_W  registered WBdata_out; WB forwarding source
- retire_cnt  out  32  committed-write counter (only with WB_RETIRE_CNT_EN)

## Operation

- MEM/WB register: each rising edge, RegWrite_WB/Rd_WB/RPzero_WB/WBvalue_WB capture the corresponding MEM inputs. No enable, no stall; WB never back-pressures.
- Commit condition: commit = RegWrite_WB & ~RPzero_WB & (Rd_WB != 0).
- Register file: NUM_REGS x DATA_W flops. On rising edge with commit, reg[Rd_WB] <= WBvalue_WB. Only one write port.
- R0: reads return 0 regardless of contents; writes to R0 never commit.
- Read ports (combinational): BusA = 0 if Rs_ID==0; else WBvalue_WB if commit & Rs_ID==Rd_WB; else reg[Rs_ID]. BusB identical with Rt_ID.
- Killed instruction (RPzero_WB=1): no write, no bypass, no counter increment; outputs still reflect latched fields so the hazard unit can suppress forwarding itself.
- Rs_ID==Rt_ID: both buses return the same value, including bypass.

## Timing

- Reset (asynchronous, immediate): RegWrite_WB=0, Rd_WB=0, RPzero_WB=0, WBvalue_WB=0, all registers 0, retire_cnt=0. Combinationally BusA=BusB=0 during and after reset until a commit.
- Reset asserted mid-operation: any pending WB write is discarded; reset wins over the simultaneous edge.
- Latency: value presented on WBdata_out before edge k appears on WBvalue_WB after edge k; visible on BusA/BusB via bypass in cycle k..k+1; stored in reg file at edge k+1; readable from array thereafter.
- Back-to-back writes to the same register: later one wins; bypass always reflects the instruction currently in WB.
- Reads are combinational from current state; no read latency.

## Configuration

- WB_RETIRE_CNT_EN defined: 32-bit retire_cnt increments by 1 on every rising edge where commit=1; wraps 0xFFFFFFFF→0; cleared by reset.
- Not defined: retire_cnt port and counter absent; all other behaviour identical.

## Structure

- Shared pipeline package: DATA_W and REG_ADDR_W constants, REG_ZERO index constant, MEM/WB bundle typedef (regwrite, rd, rpzero, value) shared with mem_stage.
- One sub-module: reg_file (array, write port, two bypassed read ports, R0 rule); wb_stage holds the MEM/WB register, commit logic and optional counter.

## Test plan

- Reset then Rs_ID=3, Rt_ID=31 -> BusA=0, BusB=0, RegWrite_WB=0, Rd_WB=0.
- RegWrite_MEM=1, Rd3_MEM=3, WBdata_out=15, one edge; Rs_ID=3 -> BusA=15 via bypass; after next edge with RegWrite_MEM=0 -> BusA=15 from array.
- RegWrite_MEM=1, Rd3_MEM=0, WBdata_out=0xDEADBEEF, two edges; Rs_ID=0 -> BusA=0; retire_cnt unchanged.
- RegWrite_MEM=1, RPzero_MEM=1, Rd3_MEM=4, WBdata_out=99 over reg4=7 -> RPzero_WB=1, Rt_ID=4 gives BusB=7 in both following cycles.
- Consecutive writes R31=100 then R31=200; Rs_ID=Rt_ID=31 -> both buses 100 then 200; final array value 200.
- WB_RETIRE_CNT_EN, counter forced near 0xFFFFFFFF via 2 commits from 0xFFFFFFFE -> reads 0xFFFFFFFF then 0; assert reset mid-cycle during a commit -> counter 0, target register 0.
